// File: rtl/line_mem_slave.sv
// line_mem_slave: Wishbone line slave that splits a 512-bit line access into
// eight 64-bit memory beats.
//   clk, rst_n              : clock (rising edge), async active-low reset
//   ws_addr/ws_din/ws_dm    : line address, write data, per-byte write enables
//   ws_cyc/ws_stb/ws_we     : Wishbone cycle, strobe, write-enable
//   ws_ack/ws_dout          : one-cycle acknowledge, read line data
//   mem_req/mem_we/mem_addr : beat request, type (1 = write), beat address
//   mem_wdata/mem_wmask     : write beat data and byte mask
//   mem_gnt                 : request accepted when mem_req && mem_gnt
//   mem_rvalid/mem_rdata    : in-order read returns
module line_mem_slave #(
    parameter bit SKIP_EMPTY_BEATS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  ws_addr,
    input  logic [511:0] ws_din,
    input  logic [63:0]  ws_dm,
    input  logic         ws_cyc,
    input  logic         ws_stb,
    input  logic         ws_we,
    output logic         ws_ack,
    output logic [511:0] ws_dout,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [63:0]  mem_wdata,
    output logic [7:0]   mem_wmask,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [63:0]  mem_rdata
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, ACK, DRAIN} state_t;

    state_t       state, stateNext;
    logic [25:0]  lineQ;
    logic [511:0] dinQ;
    logic [63:0]  dmQ;
    logic [2:0]   beatIdx, beatNext;
    logic [3:0]   rtnCnt, rtnNext;
    logic [3:0]   outCnt, outNext;
    logic         reqNext, weNext;
    logic [31:0]  addrNext;
    logic [63:0]  wdataNext;
    logic [7:0]   wmaskNext;
    logic         storeBeat, accept, readGnt, rtnOk;
    logic         present, presentWe;
    logic [2:0]   presentBeat;
    logic [3:0]   found;
    logic [25:0]  lineSel;
    logic [511:0] dinSel;
    logic [63:0]  dmSel;
    logic         unused;

    assign unused = ^ws_addr[5:0];

    // Lowest beat index >= start that must be issued; 8 means none left.
    function automatic logic [3:0] findBeat(input logic [63:0] mask, input logic [3:0] start);
        logic [3:0] idx;
        idx = 4'd8;
        for (int k = 7; k >= 0; k--) begin
            if (4'(k) >= start && (!SKIP_EMPTY_BEATS || mask[8*k +: 8] != 8'h00))
                idx = 4'(k);
        end
        return idx;
    endfunction

    // In IDLE the first beat is built from the live inputs, later beats from the latched copy.
    assign lineSel = (state == IDLE) ? ws_addr[31:6] : lineQ;
    assign dinSel  = (state == IDLE) ? ws_din : dinQ;
    assign dmSel   = (state == IDLE) ? ws_dm : dmQ;

    assign accept  = (state == IDLE) && ws_cyc && ws_stb;
    assign readGnt = mem_req && mem_gnt && !mem_we;
    assign rtnOk   = mem_rvalid && (outCnt != 4'd0);

    // Outstanding reads: grant and return in the same cycle cancel out.
    always_comb begin
        outNext = outCnt;
        case ({readGnt, rtnOk})
            2'b10:   outNext = outCnt + 4'd1;
            2'b01:   outNext = outCnt - 4'd1;
            default: outNext = outCnt;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Next state and next values of the registered request outputs.
    always_comb begin
        stateNext   = state;
        reqNext     = mem_req;
        weNext      = mem_we;
        addrNext    = mem_addr;
        wdataNext   = mem_wdata;
        wmaskNext   = mem_wmask;
        beatNext    = beatIdx;
        rtnNext     = rtnCnt;
        storeBeat   = 1'b0;
        present     = 1'b0;
        presentWe   = 1'b0;
        presentBeat = 3'd0;
        found       = 4'd8;
        case (state)
            IDLE: begin
                if (ws_cyc && ws_stb) begin
                    beatNext = 3'd0;
                    rtnNext  = 4'd0;
                    if (ws_we) begin
                        found = findBeat(ws_dm, 4'd0);
                        if (found[3]) begin
                            stateNext = ACK;
                        end else begin
                            stateNext   = WRITE;
                            present     = 1'b1;
                            presentWe   = 1'b1;
                            presentBeat = found[2:0];
                        end
                    end else begin
                        stateNext   = READ;
                        present     = 1'b1;
                        presentBeat = 3'd0;
                    end
                end
            end
            WRITE: begin
                if (!ws_cyc) begin
                    reqNext   = 1'b0;
                    stateNext = (outNext != 4'd0) ? DRAIN : IDLE;
                end else if (mem_req && mem_gnt) begin
                    // Empty beats are skipped in the same cycle as the grant.
                    found = findBeat(dmQ, {1'b0, beatIdx} + 4'd1);
                    if (found[3]) begin
                        reqNext   = 1'b0;
                        stateNext = ACK;
                    end else begin
                        present     = 1'b1;
                        presentWe   = 1'b1;
                        presentBeat = found[2:0];
                    end
                end
            end
            READ: begin
                if (!ws_cyc) begin
                    reqNext   = 1'b0;
                    stateNext = (outNext != 4'd0) ? DRAIN : IDLE;
                end else begin
                    if (mem_req && mem_gnt) begin
                        if (beatIdx == 3'd7) begin
                            reqNext = 1'b0;
                        end else begin
                            present     = 1'b1;
                            presentBeat = beatIdx + 3'd1;
                        end
                    end
                    if (rtnOk) begin
                        storeBeat = 1'b1;
                        rtnNext   = rtnCnt + 4'd1;
                        if (rtnCnt == 4'd7) begin
                            stateNext = ACK;
                            present   = 1'b0;
                            reqNext   = 1'b0;
                        end
                    end
                end
            end
            ACK:     stateNext = IDLE;
            DRAIN:   if (outNext == 4'd0) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (present) begin
            reqNext   = 1'b1;
            weNext    = presentWe;
            beatNext  = presentBeat;
            addrNext  = {lineSel, presentBeat, 3'b000};
            wdataNext = presentWe ? dinSel[{presentBeat, 6'b0} +: 64] : 64'd0;
            wmaskNext = presentWe ? dmSel[{presentBeat, 3'b0} +: 8] : 8'd0;
        end
        if (!reqNext) begin
            weNext    = 1'b0;
            wmaskNext = 8'd0;
        end
    end

    // Registered outputs, latched request and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_ack    <= 1'b0;
            ws_dout   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            lineQ     <= '0;
            dinQ      <= '0;
            dmQ       <= '0;
            beatIdx   <= '0;
            rtnCnt    <= '0;
            outCnt    <= '0;
        end else begin
            ws_ack    <= (stateNext == ACK);
            mem_req   <= reqNext;
            mem_we    <= weNext;
            mem_addr  <= addrNext;
            mem_wdata <= wdataNext;
            mem_wmask <= wmaskNext;
            beatIdx   <= beatNext;
            rtnCnt    <= rtnNext;
            outCnt    <= outNext;
            if (accept) begin
                lineQ <= ws_addr[31:6];
                dinQ  <= ws_din;
                dmQ   <= ws_dm;
            end
            if (storeBeat) ws_dout[{rtnCnt[2:0], 6'b0} +: 64] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_line_mem_slave.sv
// tb_line_mem_slave: directed and randomized checks of line_mem_slave against
// a memory model and a line-level reference of expected beats and read data.
module tb_line_mem_slave;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  ws_addr;
    logic [511:0] ws_din;
    logic [63:0]  ws_dm;
    logic         ws_cyc, ws_stb, ws_we;
    logic         ws_ack;
    logic [511:0] ws_dout;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [7:0]   mem_wmask;
    logic         mem_gnt, mem_rvalid;
    logic [63:0]  mem_rdata;

    always #5 clk = ~clk;

    line_mem_slave #(.SKIP_EMPTY_BEATS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ws_addr(ws_addr), .ws_din(ws_din), .ws_dm(ws_dm),
        .ws_cyc(ws_cyc), .ws_stb(ws_stb), .ws_we(ws_we),
        .ws_ack(ws_ack), .ws_dout(ws_dout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        int          due;
        logic [63:0] data;
    } rtn_t;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int ackTotal = 0;
    int gntMode = 0;
    int latMin = 1, latMax = 1;
    int lastDue = 0;
    int firstGntCyc = -1, lastGntCyc = -1;
    int startCyc = 0, ackCyc = 0;
    bit strayOn = 0;
    req_t req_log[$];
    rtn_t pend[$];
    logic [63:0] devMem [logic [31:0]];
    logic [63:0] refMem [logic [31:0]];
    logic [511:0] lastRead = '0;

    function automatic logic [63:0] dflt(input logic [31:0] a);
        return {~a, a} ^ 64'hA5A5_0F0F_3C3C_9696;
    endfunction

    function automatic logic [63:0] applyMask(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] devRead(input logic [31:0] a);
        if (devMem.exists(a)) return devMem[a];
        return dflt(a);
    endfunction

    function automatic logic [63:0] refRead(input logic [31:0] a);
        if (refMem.exists(a)) return refMem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] beatAddr(input logic [31:0] line, input int k);
        return {line[31:6], 6'd0} + 32'(8 * k);
    endfunction

    function automatic logic [511:0] expLine(input logic [31:0] a);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[64*k +: 64] = refRead(beatAddr(a, k));
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refWrite(input logic [31:0] a, input logic [511:0] din, input logic [63:0] dm);
        for (int k = 0; k < 8; k++)
            refMem[beatAddr(a, k)] = applyMask(refRead(beatAddr(a, k)), din[64*k +: 64], dm[8*k +: 8]);
    endtask

    // Beats with a non-empty mask, in ascending order, are the only accesses expected.
    task automatic checkWriteLog(input logic [31:0] a, input logic [511:0] din, input logic [63:0] dm);
        req_t exp[$];
        for (int k = 0; k < 8; k++)
            if (dm[8*k +: 8] != 8'h00) exp.push_back('{1'b1, beatAddr(a, k), din[64*k +: 64], dm[8*k +: 8]});
        chk("wr_count", 512'(req_log.size()), 512'(exp.size()));
        for (int i = 0; i < exp.size() && i < req_log.size(); i++)
            chk("wr_beat", 512'(req_log[i]), 512'(exp[i]));
    endtask

    task automatic checkReadLog(input logic [31:0] a);
        chk("rd_count", 512'(req_log.size()), 512'd8);
        for (int i = 0; i < 8 && i < req_log.size(); i++)
            chk("rd_beat", {req_log[i].we, req_log[i].addr, req_log[i].wmask}, {1'b0, beatAddr(a, i), 8'h00});
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [511:0] din, input logic [63:0] dm);
        ws_cyc = 1'b1; ws_stb = 1'b1; ws_we = we; ws_addr = a; ws_din = din; ws_dm = dm;
    endtask

    task automatic waitAck(output bit got);
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk); #1;
            if (ws_ack) got = 1;
        end
        ackCyc = cycle;
        chk("ack_seen", 512'(got), 512'd1);
    endtask

    task automatic runTxn(input logic we, input logic [31:0] a, input logic [511:0] din, input logic [63:0] dm);
        int startAcks;
        bit got;
        req_log.delete();
        @(negedge clk); #1;
        startCyc = cycle;
        startAcks = ackTotal;
        drive(we, a, din, dm);
        waitAck(got);
        ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0;
        @(negedge clk); #1;
        chk("ack_one_cycle", 512'(ws_ack), 512'd0);
        chk("ack_count", 512'(ackTotal - startAcks), 512'd1);
    endtask

    // Memory responder: grants, write storage and in-order delayed read returns.
    initial begin
        logic g;
        logic tog;
        int d;
        tog = 1'b1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (pend.size() != 0 && pend[0].due <= cycle) begin
                mem_rvalid = 1'b1;
                mem_rdata = pend[0].data;
                void'(pend.pop_front());
            end else if (strayOn) begin
                mem_rvalid = 1'b1;
                mem_rdata = {$urandom, $urandom};
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata = '0;
            end
            case (gntMode)
                0:       g = 1'b1;
                1:       begin g = tog; tog = ~tog; end
                default: g = 1'($urandom_range(1, 0));
            endcase
            mem_gnt = g;
            if (mem_req && g && rst_n) begin
                if (req_log.size() == 0) firstGntCyc = cycle;
                lastGntCyc = cycle;
                req_log.push_back('{mem_we, mem_addr, mem_wdata, mem_wmask});
                if (mem_we) begin
                    devMem[mem_addr] = applyMask(devRead(mem_addr), mem_wdata, mem_wmask);
                end else begin
                    d = cycle + int'($urandom_range(latMax, latMin));
                    if (d <= lastDue) d = lastDue + 1;
                    lastDue = d;
                    pend.push_back('{d, devRead(mem_addr)});
                end
            end
        end
    end

    // Count acknowledge cycles.
    initial forever begin
        @(negedge clk);
        if (ws_ack === 1'b1) ackTotal++;
    end

    initial begin
        logic [511:0] din;
        logic [63:0]  dm;
        logic [31:0]  a;
        logic         we;
        int           startAcks;
        bit           got;

        rst_n = 1'b0;
        ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0;
        ws_addr = '0; ws_din = '0; ws_dm = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ack", 512'(ws_ack), 512'd0);
        chk("rst_req", 512'(mem_req), 512'd0);
        chk("rst_we", 512'(mem_we), 512'd0);
        chk("rst_wmask", 512'(mem_wmask), 512'd0);
        chk("rst_dout", ws_dout, 512'd0);
        rst_n = 1'b1;

        // Full-mask write with grant always high.
        gntMode = 0;
        din = rand512();
        runTxn(1'b1, 32'h0001_2340, din, {64{1'b1}});
        checkWriteLog(32'h0001_2340, din, {64{1'b1}});
        refWrite(32'h0001_2340, din, {64{1'b1}});
        chk("first_accept", 512'(firstGntCyc), 512'(startCyc + 1));
        chk("wr_ack_timing", 512'(ackCyc), 512'(lastGntCyc + 1));

        // Only beat 2 has enabled bytes.
        din = rand512();
        runTxn(1'b1, 32'h0001_2340, din, 64'h0000_0000_00FF_0000);
        checkWriteLog(32'h0001_2340, din, 64'h0000_0000_00FF_0000);
        refWrite(32'h0001_2340, din, 64'h0000_0000_00FF_0000);

        // Read with alternating grant and 3-cycle return latency.
        gntMode = 1; latMin = 3; latMax = 3;
        for (int n = 0; n < 8; n++) begin
            devMem[beatAddr(32'h0002_0000, n)] = 64'h1111_1111_1111_1111 * 64'(n);
            refMem[beatAddr(32'h0002_0000, n)] = 64'h1111_1111_1111_1111 * 64'(n);
        end
        runTxn(1'b0, 32'h0002_0000, '0, '0);
        checkReadLog(32'h0002_0000);
        chk("rd_pattern", ws_dout, expLine(32'h0002_0000));
        lastRead = expLine(32'h0002_0000);

        // All-zero mask: acknowledged without any memory access.
        gntMode = 0;
        runTxn(1'b1, 32'h0003_0000, rand512(), 64'd0);
        chk("empty_no_req", 512'(req_log.size()), 512'd0);
        chk("empty_dout_hold", ws_dout, lastRead);

        // Stray returns while idle must not disturb the next read.
        strayOn = 1;
        repeat (4) @(negedge clk);
        strayOn = 0;
        repeat (2) @(negedge clk);
        latMin = 1; latMax = 4;
        runTxn(1'b0, 32'h0001_2340, '0, '0);
        chk("stray_ignored", ws_dout, expLine(32'h0001_2340));
        lastRead = expLine(32'h0001_2340);

        // Abort a read after three grants.
        gntMode = 0; latMin = 6; latMax = 6;
        req_log.delete();
        @(negedge clk); #1;
        startAcks = ackTotal;
        drive(1'b0, 32'h0004_0000, '0, '0);
        for (int i = 0; i < 50 && req_log.size() < 3; i++) begin
            @(negedge clk); #1;
        end
        ws_cyc = 1'b0; ws_stb = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("abort_grants", 512'(req_log.size()), 512'd3);
        chk("abort_no_ack", 512'(ackTotal - startAcks), 512'd0);
        chk("abort_drained", 512'(pend.size()), 512'd0);
        chk("abort_req_low", 512'(mem_req), 512'd0);
        latMin = 1; latMax = 3;
        din = rand512();
        runTxn(1'b1, 32'h0004_0040, din, {64{1'b1}});
        checkWriteLog(32'h0004_0040, din, {64{1'b1}});
        refWrite(32'h0004_0040, din, {64{1'b1}});
        runTxn(1'b0, 32'h0004_0040, '0, '0);
        chk("after_abort_rd", ws_dout, expLine(32'h0004_0040));
        lastRead = expLine(32'h0004_0040);

        // Back-to-back read then write with cyc held high.
        gntMode = 2;
        req_log.delete();
        @(negedge clk); #1;
        startAcks = ackTotal;
        drive(1'b0, 32'h0001_2340, '0, '0);
        waitAck(got);
        chk("b2b_rd", ws_dout, expLine(32'h0001_2340));
        lastRead = expLine(32'h0001_2340);
        req_log.delete();
        din = rand512();
        dm = {$urandom, $urandom};
        drive(1'b1, 32'h0005_0080, din, dm);
        waitAck(got);
        ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0;
        chk("b2b_acks", 512'(ackTotal - startAcks), 512'd2);
        checkWriteLog(32'h0005_0080, din, dm);
        refWrite(32'h0005_0080, din, dm);

        // Reset in the middle of a write after four grants.
        gntMode = 0;
        req_log.delete();
        @(negedge clk); #1;
        drive(1'b1, 32'h0006_0000, rand512(), {64{1'b1}});
        for (int i = 0; i < 50 && req_log.size() < 4; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 512'(mem_req), 512'd0);
        chk("rst_mid_ack", 512'(ws_ack), 512'd0);
        chk("rst_mid_we", 512'(mem_we), 512'd0);
        chk("rst_mid_wmask", 512'(mem_wmask), 512'd0);
        chk("rst_mid_dout", ws_dout, 512'd0);
        chk("rst_mid_grants", 512'(req_log.size()), 512'd4);
        ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        lastRead = '0;
        din = rand512();
        runTxn(1'b1, 32'h0006_0000, din, {64{1'b1}});
        checkWriteLog(32'h0006_0000, din, {64{1'b1}});
        refWrite(32'h0006_0000, din, {64{1'b1}});

        // Randomized mix over a small address window.
        gntMode = 2; latMin = 1; latMax = 5;
        for (int t = 0; t < 24; t++) begin
            we = 1'($urandom_range(1, 0));
            a = 32'h0010_0000 | ($urandom & 32'h0000_01C0) | ($urandom & 32'h3F);
            din = rand512();
            case ($urandom_range(3, 0))
                0: dm = {64{1'b1}};
                1: dm = 64'd0;
                2: dm = {$urandom, $urandom};
                default: begin
                    dm = {$urandom, $urandom};
                    for (int k = 0; k < 8; k++) if ($urandom_range(1, 0) == 0) dm[8*k +: 8] = 8'h00;
                end
            endcase
            runTxn(we, a, din, dm);
            if (we) begin
                checkWriteLog(a, din, dm);
                refWrite(a, din, dm);
                chk("dout_hold", ws_dout, lastRead);
            end else begin
                checkReadLog(a);
                chk("rd_data", ws_dout, expLine(a));
                lastRead = expLine(a);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_mem_slave.md
LINE_MEM_SLAVE -- requirements
Module: line_mem_slave

Interface
REQ-001 The block SHALL have parameter SKIP_EMPTY_BEATS, default 1, meaning write beats with an all-zero byte mask are not issued to memory.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port ws_addr, input, 32 bits: line byte address; bits [5:0] are ignored.
REQ-005 The block SHALL have port ws_din, input, 512 bits: write line data; beat k is bits [64k+63:64k].
REQ-006 The block SHALL have port ws_dm, input, 64 bits: per-byte write enables (1 = write); beat k uses bits [8k+7:8k].
REQ-007 The block SHALL have ports ws_cyc, ws_stb and ws_we, each input, 1 bit: Wishbone cycle, strobe and write-enable.
REQ-008 The block SHALL have port ws_ack, output, 1 bit: registered one-cycle acknowledge.
REQ-009 The block SHALL have port ws_dout, output, 512 bits: read line data, valid while ws_ack=1.
REQ-010 The block SHALL have ports mem_req and mem_we, each output, 1 bit: memory request valid, and request type (1 = write).
REQ-011 The block SHALL have port mem_addr, output, 32 bits: beat address {line[31:6], k[2:0], 3'b000}.
REQ-012 The block SHALL have ports mem_wdata (output, 64 bits) and mem_wmask (output, 8 bits): write beat data and byte mask.
REQ-013 The block SHALL have port mem_gnt, input, 1 bit: the request is accepted in any cycle where mem_req=1 and mem_gnt=1.
REQ-014 The block SHALL have ports mem_rvalid (input, 1 bit) and mem_rdata (input, 64 bits): in-order read return, of arbitrary latency of at least 1 cycle.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, WRITE, READ, ACK and DRAIN.
REQ-016 In IDLE with ws_cyc=1 and ws_stb=1, the block SHALL latch ws_addr[31:6], ws_din and ws_dm, clear the beat counters, and go to WRITE if ws_we=1, else READ.
REQ-017 In WRITE, the block SHALL present beats k=0..7 in ascending order, holding mem_req, mem_we=1, mem_addr, mem_wdata and mem_wmask stable until granted.
REQ-018 In WRITE, the beat index SHALL advance only on grant.
REQ-019 With SKIP_EMPTY_BEATS=1, a beat whose mask is 8'h00 SHALL be skipped without a memory access, at zero-cycle cost per skipped beat where possible and at most 1 cycle per skipped beat.
REQ-020 When beat 7 is granted (or skipped), the block SHALL go to ACK; a line with ws_dm all zero SHALL reach ACK without asserting mem_req.
REQ-021 In READ, the block SHALL issue 8 read requests (mem_we=0, mem_wmask=0) in ascending beat order, independently of returns.
REQ-022 The block SHALL store the n-th mem_rvalid beat of a transaction into ws_dout[64n+63:64n].
REQ-023 After the 8th return the block SHALL go to ACK, including when the 8th return coincides with the last grant.
REQ-024 ACK SHALL assert ws_ack=1 for exactly one cycle, then return to IDLE; ws_ack SHALL be 0 in every other state.
REQ-025 A new request SHALL be accepted no earlier than the cycle after ACK; stb held in that IDLE cycle with new cyc/stb/we SHALL start a new transaction (back-to-back read then write with cyc held high).
REQ-026 The block SHALL maintain a 4-bit outstanding-read counter: +1 on read grant, -1 on mem_rvalid, with both in one cycle leaving it unchanged.
REQ-027 ws_cyc=0 during WRITE or READ SHALL abort: mem_req deasserts the next cycle and no ws_ack is issued.
REQ-028 On abort, the block SHALL go to DRAIN if the outstanding count is nonzero (discarding returns until it reaches 0), else to IDLE.
REQ-029 A mem_rvalid with outstanding count 0 SHALL be ignored.
REQ-030 ws_dout SHALL hold its value after ACK until overwritten by the next read.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force the state to IDLE, ws_ack=0, mem_req=0, mem_we=0, mem_wmask=0, ws_dout=0 and all counters to 0, including mid-transaction.
REQ-032 After rst_n rises, the first request SHALL be accepted on the first clock edge where ws_cyc=ws_stb=1.

Verification
REQ-033 Write, addr 32'h0001_2340, ws_dm all ones, mem_gnt always 1 -> 8 writes at 32'h0001_2340..32'h0001_2378 step 8, masks 8'hFF, ws_ack on the cycle after the last grant.
REQ-034 Write with ws_dm=64'h0000_0000_00FF_0000, SKIP_EMPTY_BEATS=1 -> exactly one write at line+16 with mask 8'hFF, followed by one ws_ack.
REQ-035 Read with mem_gnt toggling 1010... and returns delayed 3 cycles, data beat n = 64'h1111_1111_1111_1111*n -> ws_dout matches, single ws_ack.
REQ-036 Read with ws_cyc dropped after 3 grants -> no ws_ack, 3 returns drained, IDLE reached, and a following write completes correctly.
REQ-037 rst_n pulsed low mid-WRITE after 4 grants -> mem_req=0 immediately, and the next write starts at beat 0.
